ro_puf_bank: RTL and testbench

//  Bank of NUM_RO enable-gated ring oscillators plus measurement FSM: races a selected

---
 rtl/ro_puf_bank.sv | 180 ++++++++++++++++++
 tb/tb_ro_puf_bank.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ro_puf_bank.sv
`timescale 1ns/1ps
// ro_puf_bank: NUM_RO enable-gated ring oscillators; a selected pair races for WINDOW clk cycles
// and the faster ring (A > B) yields resp. Define PUF_RAW_COUNT_EN to expose count_a/count_b.
module ro_puf_bank #(
    parameter  int NUM_RO = 16,
    parameter  int STAGES = 5,
    parameter  int CNT_W  = 16,
    parameter  int WINDOW = 4096,
    parameter  int SETTLE = 4,
    localparam int SEL_W  = $clog2(NUM_RO)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SEL_W-1:0] sel_a,
    input  logic [SEL_W-1:0] sel_b,
    output logic             busy,
    output logic             done,
    output logic             resp,
    output logic             sat,
    output logic             err
`ifdef PUF_RAW_COUNT_EN
    ,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b
`endif
);

    localparam int SEL_SPAN = 2 ** SEL_W;
    localparam int TMR_W    = $clog2(WINDOW + SETTLE + 2);

    function automatic logic [SEL_SPAN-1:0] valid_mask();
        logic [SEL_SPAN-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_RO; i++) m[i] = 1'b1;
        return m;
    endfunction

    localparam logic [SEL_SPAN-1:0] VALID = valid_mask();

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_HOLD, S_CMP} state_t;

    state_t             state;
    logic [TMR_W-1:0]   tmr;
    logic [SEL_W-1:0]   idx_a, idx_b;
    logic [NUM_RO-1:0]  ro_en;
    logic [NUM_RO-1:0]  ro_out;
    logic [SEL_SPAN-1:0] ro_ext;
    logic               cnt_clr;
    logic               cnt_rst_n;
    logic               ring_clk_a, ring_clk_b;
    logic [CNT_W-1:0]   cnt_a, cnt_b;
    logic               sel_err;

    // Ring: one NAND (enable) followed by STAGES-1 inverters; idles high when disabled.
    for (genvar i = 0; i < NUM_RO; i++) begin : g_ring
        (* keep = "true", dont_touch = "true" *) logic [STAGES-1:0] node;
        assign node[0] = ~(ro_en[i] & ro_out[i]);
        for (genvar s = 1; s < STAGES; s++) begin : g_inv
            assign node[s] = ~node[s-1];
        end
        assign ro_out[i] = node[STAGES-1];
    end

    always_comb begin
        // NOTE: default first so every path assigns ro_ext and no latch is inferred.
        ro_ext = '0;
        ro_ext[NUM_RO-1:0] = ro_out;
    end

    // Mux selects move only in IDLE while every ring sits high, so counter clocks never glitch.
    assign ring_clk_a = ro_ext[idx_a];
    assign ring_clk_b = ro_ext[idx_b];

    assign sel_err   = (sel_a == sel_b) || !VALID[sel_a] || !VALID[sel_b];
    // NOTE: counter clear merges system reset with the registered CLEAR strobe; both are async.
    assign cnt_rst_n = rst_n & ~cnt_clr;

    always_ff @(posedge ring_clk_a or negedge cnt_rst_n) begin
        if (!cnt_rst_n)       cnt_a <= '0;
        else if (~&cnt_a)     cnt_a <= cnt_a + CNT_W'(1);
    end

    always_ff @(posedge ring_clk_b or negedge cnt_rst_n) begin
        if (!cnt_rst_n)       cnt_b <= '0;
        else if (~&cnt_b)     cnt_b <= cnt_b + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            tmr     <= '0;
            idx_a   <= '0;
            idx_b   <= '0;
            ro_en   <= '0;
            cnt_clr <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            resp    <= 1'b0;
            sat     <= 1'b0;
            err     <= 1'b0;
`ifdef PUF_RAW_COUNT_EN
            count_a <= '0;
            count_b <= '0;
`endif
        end else begin
            // NOTE: non-blocking default makes done a single-cycle pulse.
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx_a <= sel_a;
                        idx_b <= sel_b;
                        busy  <= 1'b1;
                        resp  <= 1'b0;
                        sat   <= 1'b0;
                        err   <= sel_err;
                        if (sel_err) begin
                            state <= S_CMP;
                            done  <= 1'b1;
`ifdef PUF_RAW_COUNT_EN
                            count_a <= '0;
                            count_b <= '0;
`endif
                        end else begin
                            state   <= S_CLEAR;
                            cnt_clr <= 1'b1;
                            tmr     <= TMR_W'(1);
                        end
                    end
                end
                S_CLEAR: begin
                    if (tmr == '0) begin
                        cnt_clr <= 1'b0;
                        ro_en   <= (NUM_RO'(1) << idx_a) | (NUM_RO'(1) << idx_b);
                        tmr     <= TMR_W'(WINDOW - 1);
                        state   <= S_RUN;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                S_RUN: begin
                    if (tmr == '0) begin
                        ro_en <= '0;
                        tmr   <= TMR_W'(SETTLE - 1);
                        state <= S_HOLD;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                S_HOLD: begin
                    // Rings have been stopped for SETTLE cycles, so the counts are static here.
                    if (tmr == '0) begin
                        resp  <= (cnt_a > cnt_b);
                        sat   <= (&cnt_a) | (&cnt_b);
                        done  <= 1'b1;
                        state <= S_CMP;
`ifdef PUF_RAW_COUNT_EN
                        count_a <= cnt_a;
                        count_b <= cnt_b;
`endif
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                S_CMP: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    ro_en   <= '0;
                    cnt_clr <= 1'b0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ro_puf_bank.sv
`timescale 1ns/100ps
// tb_ro_puf_bank: directed races with behavioural ring models forced onto the ring outputs;
// a CNT_W=6 instance shares the stimulus to cover saturation.
module tb_ro_puf_bank;

    localparam int NUM_RO = 16;
    localparam int WINDOW = 64;
    localparam int SETTLE = 4;
    localparam int LAT    = WINDOW + SETTLE + 3;

    logic       clk, rst_n, start;
    logic [3:0] sel_a, sel_b;
    logic       busy, done, resp, sat, err;
    logic       s_busy, s_done, s_resp, s_sat, s_err;
`ifdef PUF_RAW_COUNT_EN
    logic [15:0] count_a, count_b;
    logic [5:0]  s_count_a, s_count_b;
`endif

    logic [NUM_RO-1:0] ro_m, ro_s;
    real               hp [NUM_RO];
    int                n_checks, n_errs, done_cnt, cyc, d0;
    logic              en_seen;

    ro_puf_bank #(.NUM_RO(NUM_RO), .STAGES(5), .CNT_W(16), .WINDOW(WINDOW), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sel_a(sel_a), .sel_b(sel_b),
        .busy(busy), .done(done), .resp(resp), .sat(sat), .err(err)
`ifdef PUF_RAW_COUNT_EN
        , .count_a(count_a), .count_b(count_b)
`endif
    );

    ro_puf_bank #(.NUM_RO(NUM_RO), .STAGES(5), .CNT_W(6), .WINDOW(WINDOW), .SETTLE(SETTLE)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .sel_a(sel_a), .sel_b(sel_b),
        .busy(s_busy), .done(s_done), .resp(s_resp), .sat(s_sat), .err(s_err)
`ifdef PUF_RAW_COUNT_EN
        , .count_a(s_count_a), .count_b(s_count_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ring model: idles high; 0.1 ns after enable it toggles every hp[i]; returns high when disabled.
    for (genvar i = 0; i < NUM_RO; i++) begin : g_model
        logic rm, rs;
        assign ro_m[i] = rm;
        assign ro_s[i] = rs;
        initial begin
            rm = 1'b1;
            forever begin
                wait (dut.ro_en[i]);
                #0.1;
                while (dut.ro_en[i]) begin
                    #(hp[i]);
                    rm = ~rm;
                end
                rm = 1'b1;
            end
        end
        initial begin
            rs = 1'b1;
            forever begin
                wait (u_sat.ro_en[i]);
                #0.1;
                while (u_sat.ro_en[i]) begin
                    #(hp[i]);
                    rs = ~rs;
                end
                rs = 1'b1;
            end
        end
    end

    initial begin
        force dut.ro_out   = ro_m;
        force u_sat.ro_out = ro_s;
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if ((|dut.ro_en) || (|u_sat.ro_en)) en_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Launch a race and return the cycle (relative to the start cycle) where done was seen.
    task automatic race(input logic [3:0] a, input logic [3:0] b, output int c);
        @(negedge clk);
        sel_a = a;
        sel_b = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (!done && c < 200) begin
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errs   = 0;
        done_cnt = 0;
        en_seen  = 1'b0;
        rst_n    = 1'b0;
        start    = 1'b0;
        sel_a    = '0;
        sel_b    = '0;
        for (int i = 0; i < NUM_RO; i++) hp[i] = 3.0 + 0.25 * i;
        hp[5] = 2.0;
        hp[9] = 2.5;
        hp[2] = 2.0;
        hp[7] = 20.0;

        repeat (3) @(negedge clk);
        check("reset_outs", {busy, done, resp, sat, err, s_busy, s_done}, 0);
        check("reset_en", {dut.ro_en, u_sat.ro_en}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: A=2.0 ns, B=2.5 ns
        race(4'd5, 4'd9, cyc);
        check("s1_latency", cyc, LAT);
        check("s1_resp", resp, 1);
        check("s1_sat_err", {sat, err}, 0);
        check("s1_busy_at_done", busy, 1);
`ifdef PUF_RAW_COUNT_EN
        check("s1_count_a", count_a, 160);
        check("s1_count_b", count_b, 128);
`endif
        @(negedge clk);
        check("s1_after_done", {busy, done}, 0);
        check("s1_resp_held", resp, 1);

        // 2: swapped pair
        race(4'd9, 4'd5, cyc);
        check("s2_latency", cyc, LAT);
        check("s2_resp", resp, 0);
`ifdef PUF_RAW_COUNT_EN
        check("s2_count_a", count_a, 128);
        check("s2_count_b", count_b, 160);
`endif

        // 3: equal half-periods -> tie -> 0
        race(4'd5, 4'd2, cyc);
        check("s3_resp", resp, 0);
        check("s3_sat", sat, 0);
`ifdef PUF_RAW_COUNT_EN
        check("s3_count_a", count_a, 160);
        check("s3_count_b", count_b, 160);
`endif

        // 4: identical indices -> immediate error, rings untouched
        @(negedge clk);
        en_seen = 1'b0;
        race(4'd3, 4'd3, cyc);
        check("s4_latency", cyc, 1);
        check("s4_err_resp_sat", {err, resp, sat}, 3'b100);
        repeat (3) @(negedge clk);
        check("s4_no_enable", en_seen, 0);
        check("s4_idle", busy, 0);

        // 5: CNT_W=6 instance saturates on A=2.0 ns; B=20 ns gives 16
        race(4'd5, 4'd7, cyc);
        check("s5_done", s_done, 1);
        check("s5_sat", s_sat, 1);
        check("s5_resp", s_resp, 1);
        check("s5_main_sat", sat, 0);
`ifdef PUF_RAW_COUNT_EN
        check("s5_count_a", s_count_a, 63);
        check("s5_count_b", s_count_b, 16);
        check("s5_main_count_b", count_b, 16);
`endif

        // 6: reset in RUN, then a fresh race with an ignored start while busy
        @(negedge clk);
        sel_a = 4'd5;
        sel_b = 4'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (22) @(negedge clk);
        check("s6_running_en", dut.ro_en, 32'h0220);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("s6_rst_en", {dut.ro_en, u_sat.ro_en}, 0);
        check("s6_rst_outs", {busy, done, resp, sat, err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (90) @(negedge clk);
        check("s6_no_done", done_cnt - d0, 0);

        d0 = done_cnt;
        sel_a = 4'd5;
        sel_b = 4'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            if (cyc == 10) begin
                start = 1'b1;
                sel_a = 4'd9;
                sel_b = 4'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("s6_latency", cyc, LAT);
        check("s6_resp", resp, 1);
`ifdef PUF_RAW_COUNT_EN
        check("s6_count_a", count_a, 160);
`endif
        repeat (100) @(negedge clk);
        check("s6_one_done", done_cnt - d0, 1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
